data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the byte address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the word width.
REQ-003 The block SHALL have parameter DEPTH, default 64, meaning the number of words of storage.
REQ-004 The block SHALL have parameter WAIT, default 2, meaning the wait-state cycles inserted before ack (range 0..15).

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state changes occur on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port req, input, 1 bit: the processor-side request, held high until ack.
REQ-008 The block SHALL have port we, input, 1 bit: 1 = store, 0 = load; stable while req is high.
REQ-009 The block SHALL have port addr, input, ADDR_W bits: byte address; stable while req is high.
REQ-010 The block SHALL have port wdata, input, DATA_W bits: store data; stable while req is high.
REQ-011 The block SHALL have port ack, output, 1 bit: a one-cycle completion pulse.
REQ-012 The block SHALL have port rdata, output, DATA_W bits: load result, valid while ack is high.
REQ-013 The block SHALL have port err, output, 1 bit: error status, valid while ack is high.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAITING and RESP.
REQ-016 In IDLE, when req=1 is sampled at a rising edge, the block SHALL latch we, addr and wdata, load the wait counter with WAIT, and transition to WAITING if WAIT>0, otherwise to RESP.
REQ-017 In WAITING, the counter SHALL decrement each cycle, and the FSM SHALL transition to RESP on the edge at which the counter equals 1.
REQ-018 In RESP, ack SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-019 Ack SHALL rise exactly WAIT+1 cycles after the accepting edge.
REQ-020 The word index SHALL be latched addr[ADDR_W-1:2].
REQ-021 A request SHALL be an error if latched addr[1:0] != 0 or the word index >= DEPTH.
REQ-022 A valid store SHALL write mem[index] <= wdata on the edge entering RESP, so that any later load observes the new data.
REQ-023 A valid load SHALL register rdata <= mem[index] on the edge entering RESP.
REQ-024 On an error, the block SHALL perform no write, set rdata = 0 and set err = 1 for the RESP cycle.
REQ-025 rdata and err SHALL hold their values after ack falls, until the next RESP.
REQ-026 If req is still high in the IDLE cycle following RESP, the block SHALL treat it as a new transaction (back-to-back allowed), giving a minimum spacing of WAIT+2 cycles between acks.
REQ-027 Changes to req, we, addr or wdata while busy=1 SHALL be ignored, because the latched copies are used.
REQ-028 A req that falls before ack SHALL NOT abort the transaction, and ack SHALL still be issued.

Reset
REQ-029 When rst=0, the block SHALL force state to IDLE, counter = 0, ack = 0, err = 0, rdata = 0 and busy = 0, without waiting for a clock edge.
REQ-030 Memory contents SHALL NOT be altered by reset.
REQ-031 If reset is asserted in WAITING, the pending store SHALL be discarded with no write and no ack.
REQ-032 After rst returns to 1, the first rising edge SHALL be able to accept a request.

Verification
REQ-033 Store addr=0x010, wdata=0xDEADBEEF, WAIT=2 -> ack rises exactly 3 cycles after the accepting edge, lasts 1 cycle, err=0.
REQ-034 Load addr=0x010 after REQ-033 -> rdata=0xDEADBEEF during ack, err=0.
REQ-035 Load addr=0x012 (misaligned) and load addr=0x100 (index 64 >= DEPTH) -> err=1 and rdata=0 for each; a store to 0x100 leaves mem[0] unchanged.
REQ-036 req held high across 3 back-to-back loads, WAIT=0 -> ack pulses spaced exactly 2 cycles apart, with busy high on each RESP cycle.
REQ-037 Store to 0x020 with wdata=0x12345678, rst pulsed low mid-WAITING, then load 0x020 -> old contents returned, no ack from the aborted store, all outputs 0 during reset.
REQ-038 Change addr and wdata while busy=1 -> response reflects the originally latched values.

Source files
------------

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//
// Word-organised data memory that answers a processor-side req/ack handshake
// after a fixed number of wait states. A request is latched when accepted,
// so the processor may change or drop its request lines once busy is high.
// Misaligned or out-of-range byte addresses complete with err=1 and rdata=0
// and never touch storage.
//
// Parameters:
//   ADDR_W - byte address width
//   DATA_W - word width
//   DEPTH  - number of words of storage
//   WAIT   - wait-state cycles inserted before ack (0..15)
//
// Ports:
//   clk    - single clock, rising edge
//   rst    - asynchronous active-low reset
//   req    - request, held high by the processor until ack
//   we     - 1 = store, 0 = load
//   addr   - byte address
//   wdata  - store data
//   ack    - one-cycle completion pulse
//   rdata  - load result, valid during ack, held until the next response
//   err    - error status, valid during ack, held until the next response
//   busy   - high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]        cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [31:0]       word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              addr_err;
    logic              accept;
    logic              enter_resp;

    logic [DATA_W-1:0] mem [DEPTH];

    // With WAIT=0 the response is produced on the accepting edge itself, before
    // the latched copies exist, so the live inputs are used while idle and the
    // latched copies at every other time.
    always_comb begin
        cur_we    = lat_we;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        if (state == IDLE) begin
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = wdata;
        end
        word_idx   = 32'(cur_addr[ADDR_W-1:2]);
        mem_idx    = word_idx[IDX_W-1:0];
        addr_err   = (cur_addr[1:0] != 2'b00) || (word_idx >= 32'(DEPTH));
        accept     = (state == IDLE) && req;
        enter_resp = (accept && (WAIT == 0)) || ((state == WAITING) && (cnt == 4'd1));
    end

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: RESP always lasts exactly one cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_next = (WAIT == 0) ? RESP : WAITING;
                end
            end
            WAITING: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ack  = (state == RESP);
        busy = (state != IDLE);
    end

    // Request latches, wait counter and the registered response. rdata keeps
    // its value across stores so the last load result stays visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= we;
                lat_addr  <= addr;
                lat_wdata <= wdata;
                cnt       <= WAIT_CNT;
            end else if (state == WAITING) begin
                cnt <= cnt - 4'd1;
            end

            if (enter_resp) begin
                if (addr_err) begin
                    rdata <= '0;
                    err   <= 1'b1;
                end else begin
                    err <= 1'b0;
                    if (!cur_we) begin
                        rdata <= mem[mem_idx];
                    end
                end
            end
        end
    end

    // Storage has no reset so its contents survive one; a reset while
    // waiting leaves the FSM idle, so a pending store never commits.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !addr_err) begin
            mem[mem_idx] <= cur_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Two instances: dut_a uses WAIT=2 for the single-transaction vectors, the
// latch/abort sequences and the reset sequence; dut_b uses WAIT=0 for
// back-to-back traffic with req held high. Expected responses are queued when
// a request is driven and compared by a monitor whenever ack is seen.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int WAIT_A = 2;
    localparam int NV     = 15;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              chk_rdata;
    } exp_t;

    logic              clk;
    logic              rst;

    logic              req_a, we_a, ack_a, err_a, busy_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a, rdata_a;

    logic              req_b, we_b, ack_b, err_b, busy_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b, rdata_b;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t vecs[NV];

    int tests = 0;
    int fails = 0;

    data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT(WAIT_A)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .ack(ack_a), .rdata(rdata_a), .err(err_a), .busy(busy_a)
    );

    data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .ack(ack_b), .rdata(rdata_b), .err(err_b), .busy(busy_b)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard for dut_a: every ack must match the oldest queued request.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ack_a) begin
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected ack_a: got ack=1, expected ack=0 with no request pending");
            end else begin
                e = q_a.pop_front();
                if (e.chk_rdata) checkOutput("sb rdata_a", rdata_a, e.rdata);
                checkOutput("sb err_a", err_a, 32'(e.err));
            end
        end
    end

    // Scoreboard for dut_b.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (ack_b) begin
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected ack_b: got ack=1, expected ack=0 with no request pending");
            end else begin
                e = q_b.pop_front();
                if (e.chk_rdata) checkOutput("sb rdata_b", rdata_b, e.rdata);
                checkOutput("sb err_b", err_b, 32'(e.err));
            end
        end
    end

    // One transaction on dut_a, started from IDLE away from a clock edge. The
    // accepting edge opens cycle 1; ack must be seen in cycle WAIT_A+1 and last
    // one cycle. With mutate set, every request line is scrambled and req is
    // dropped right after acceptance.
    task automatic applyStimulus(input logic t_we, input logic [ADDR_W-1:0] t_addr,
                                 input logic [DATA_W-1:0] t_wdata, input logic [DATA_W-1:0] t_rdata,
                                 input logic t_err, input logic mutate);
        exp_t e;
        int   cyc;
        req_a   = 1'b1;
        we_a    = t_we;
        addr_a  = t_addr;
        wdata_a = t_wdata;
        e.rdata     = t_rdata;
        e.err       = t_err;
        e.chk_rdata = !t_we || t_err;
        q_a.push_back(e);
        @(posedge clk);
        #1;
        checkOutput("busy after accept", 32'(busy_a), 32'd1);
        if (mutate) begin
            we_a    = ~t_we;
            addr_a  = ~t_addr;
            wdata_a = ~t_wdata;
            req_a   = 1'b0;
        end
        cyc = 1;
        while (!ack_a && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("ack latency", 32'(cyc), 32'(WAIT_A + 1));
        req_a = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ack width", 32'(ack_a), 32'd0);
        checkOutput("busy back to idle", 32'(busy_a), 32'd0);
        if (e.chk_rdata) checkOutput("rdata hold", rdata_a, t_rdata);
        checkOutput("err hold", 32'(err_a), 32'(t_err));
    endtask

    // Three back-to-back transactions on dut_b with req held high throughout;
    // the next request is presented during each RESP cycle.
    task automatic runBackToBack(input logic t_we);
        logic [ADDR_W-1:0] ad[3];
        logic [DATA_W-1:0] dt[3];
        exp_t e;
        int   n;
        int   cyc;
        int   last;
        ad = '{10'h000, 10'h004, 10'h008};
        dt = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002};
        n    = 0;
        cyc  = 0;
        last = 0;
        req_b   = 1'b1;
        we_b    = t_we;
        addr_b  = ad[0];
        wdata_b = dt[0];
        e.rdata     = dt[0];
        e.err       = 1'b0;
        e.chk_rdata = !t_we;
        q_b.push_back(e);
        while (n < 3 && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ack_b) begin
                checkOutput("b busy on resp", 32'(busy_b), 32'd1);
                if (n > 0) checkOutput("b ack spacing", 32'(cyc - last), 32'd2);
                last = cyc;
                n++;
                if (n < 3) begin
                    addr_b  = ad[n];
                    wdata_b = dt[n];
                    e.rdata = dt[n];
                    q_b.push_back(e);
                end else begin
                    req_b = 1'b0;
                end
            end
        end
        checkOutput("b ack count", 32'(n), 32'd3);
        @(posedge clk);
        #1;
        checkOutput("b idle after burst", 32'(busy_b), 32'd0);
    endtask

    // Main sequence: reset, vector table, latch/abort, reset mid-wait, burst.
    initial begin
        vecs[0]  = '{1'b1, 10'h010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 10'h010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 10'h012, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b0, 10'h100, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b1, 10'h000, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b1, 10'h100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b0, 10'h000, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
        vecs[7]  = '{1'b1, 10'h0FC, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 10'h0FC, 32'h0000_0000, 32'h0BAD_F00D, 1'b0};
        vecs[9]  = '{1'b1, 10'h011, 32'h7777_7777, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 10'h010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{1'b0, 10'h3FC, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 10'h020, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b1, 10'h044, 32'h5555_6666, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 10'h020, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};

        rst     = 1'b1;
        req_a   = 1'b0;
        we_a    = 1'b0;
        addr_a  = '0;
        wdata_a = '0;
        req_b   = 1'b0;
        we_b    = 1'b0;
        addr_b  = '0;
        wdata_b = '0;

        #2 rst = 1'b0;
        #1;
        checkOutput("reset ack", 32'(ack_a), 32'd0);
        checkOutput("reset busy", 32'(busy_a), 32'd0);
        checkOutput("reset err", 32'(err_a), 32'd0);
        checkOutput("reset rdata", rdata_a, 32'd0);
        checkOutput("reset busy_b", 32'(busy_b), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
        end

        // Store whose lines are scrambled and req dropped once accepted.
        applyStimulus(1'b1, 10'h040, 32'h1111_2222, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 10'h040, 32'h0, 32'h1111_2222, 1'b0, 1'b0);
        applyStimulus(1'b0, 10'h044, 32'h0, 32'h5555_6666, 1'b0, 1'b0);

        // Reset in WAITING discards a pending store to 0x020.
        req_a   = 1'b1;
        we_a    = 1'b1;
        addr_a  = 10'h020;
        wdata_a = 32'h1234_5678;
        @(posedge clk);
        #1;
        checkOutput("busy before abort", 32'(busy_a), 32'd1);
        @(negedge clk);
        rst   = 1'b0;
        req_a = 1'b0;
        #1;
        checkOutput("mid reset ack", 32'(ack_a), 32'd0);
        checkOutput("mid reset busy", 32'(busy_a), 32'd0);
        checkOutput("mid reset err", 32'(err_a), 32'd0);
        checkOutput("mid reset rdata", rdata_a, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("held reset ack", 32'(ack_a), 32'd0);
        checkOutput("held reset busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 10'h020, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);

        runBackToBack(1'b1);
        runBackToBack(1'b0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard a drained", 32'(q_a.size()), 32'd0);
        checkOutput("scoreboard b drained", 32'(q_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
